// File: rtl/tail_light_sequencer_if.sv
// Switch/tick inputs and lamp/phase/hex outputs of the tail-light sequencer.
// The master drives the requests and the slave (the sequencer) drives the lamps.
interface tail_light_sequencer_if;
  localparam int unsigned BANK_W  = 3;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned HEX_W   = 8;

  logic               tick;
  logic               hazards;
  logic               turn_en;
  logic               turn_right;
  logic               brake;
  logic [BANK_W-1:0]  left_leds;
  logic [BANK_W-1:0]  right_leds;
  logic [PHASE_W-1:0] phase;
  logic [HEX_W-1:0]   hex;

  modport master (
    output tick, hazards, turn_en, turn_right, brake,
    input  left_leds, right_leds, phase, hex
  );

  modport slave (
    input  tick, hazards, turn_en, turn_right, brake,
    output left_leds, right_leds, phase, hex
  );
endinterface

// File: rtl/tail_light_sequencer.sv
// Tail-lamp sequencer: idle, brake, hazard and turn modes with a stepped 3-lamp pattern.
// Define TAIL_LIGHT_HEX_EN to generate the seven-segment phase decode; otherwise hex is FF.
module tail_light_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  tail_light_sequencer_if.slave bus
);
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned BANK_W  = 3;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned HEX_W   = 8;
  localparam int unsigned SW_W    = 4;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_STEP - 1);

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_BRAKE_ALL,
    MODE_HAZARD,
    MODE_TURN_L,
    MODE_TURN_R
  } mode_t;

  logic [SW_W-1:0]    meta_q;
  logic [SW_W-1:0]    sync_q;
  mode_t              mode_q;
  mode_t              mode_c;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_nx;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_nx;
  logic [BANK_W-1:0]  left_q;
  logic [BANK_W-1:0]  right_q;
  logic [BANK_W-1:0]  left_nx;
  logic [BANK_W-1:0]  right_nx;
  logic               hazards_s;
  logic               turn_en_s;
  logic               turn_right_s;
  logic               brake_s;
  logic               seq_run;

  assign {hazards_s, turn_en_s, turn_right_s, brake_s} = sync_q;

  function automatic logic [BANK_W-1:0] pattern(input logic [PHASE_W-1:0] ph);
    logic [BANK_W-1:0] p;
    case (ph)
      2'd0:    p = 3'b000;
      2'd1:    p = 3'b001;
      2'd2:    p = 3'b011;
      default: p = 3'b111;
    endcase
    return p;
  endfunction

  // Mode priority: brake overrides everything unless a turn is signalling without hazards.
  always_comb begin
    mode_c = MODE_IDLE;
    if (brake_s && (hazards_s || !turn_en_s)) begin
      mode_c = MODE_BRAKE_ALL;
    end else if (hazards_s) begin
      mode_c = MODE_HAZARD;
    end else if (turn_en_s && !turn_right_s) begin
      mode_c = MODE_TURN_L;
    end else if (turn_en_s) begin
      mode_c = MODE_TURN_R;
    end
  end

  assign seq_run = (mode_c == MODE_HAZARD) || (mode_c == MODE_TURN_L) ||
                   (mode_c == MODE_TURN_R);

  // Prescaler and phase; a mode change restarts both and swallows a coincident tick.
  always_comb begin
    presc_nx = presc_q;
    phase_nx = phase_q;
    if ((mode_c != mode_q) || !seq_run) begin
      presc_nx = '0;
      phase_nx = '0;
    end else if (bus.tick) begin
      if (presc_q == PRESC_LAST) begin
        presc_nx = '0;
        phase_nx = phase_q + PHASE_W'(1);
      end else begin
        presc_nx = presc_q + PRESC_W'(1);
      end
    end
  end

  // Lamp banks derived from the upcoming phase so they stay aligned with it.
  always_comb begin
    left_nx  = '0;
    right_nx = '0;
    unique case (mode_c)
      MODE_BRAKE_ALL: begin
        left_nx  = '1;
        right_nx = '1;
      end
      MODE_HAZARD: begin
        left_nx  = pattern(phase_nx);
        right_nx = pattern(phase_nx);
      end
      MODE_TURN_L: begin
        left_nx  = pattern(phase_nx);
        right_nx = brake_s ? '1 : '0;
      end
      MODE_TURN_R: begin
        left_nx  = brake_s ? '1 : '0;
        right_nx = pattern(phase_nx);
      end
      default: begin
        left_nx  = '0;
        right_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      mode_q  <= MODE_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      meta_q  <= {bus.hazards, bus.turn_en, bus.turn_right, bus.brake};
      sync_q  <= meta_q;
      mode_q  <= mode_c;
      presc_q <= presc_nx;
      phase_q <= phase_nx;
      left_q  <= left_nx;
      right_q <= right_nx;
    end
  end

  assign bus.left_leds  = left_q;
  assign bus.right_leds = right_q;
  assign bus.phase      = phase_q;

`ifdef TAIL_LIGHT_HEX_EN
  logic [HEX_W-1:0] hex_q;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [HEX_W-1:0] seg_of(input logic [PHASE_W-1:0] ph);
    logic [HEX_W-1:0] s;
    case (ph)
      2'd0:    s = 8'hC0;
      2'd1:    s = 8'hF9;
      2'd2:    s = 8'hA4;
      default: s = 8'hB0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex_q <= 8'hC0;
    end else begin
      hex_q <= seg_of(phase_nx);
    end
  end

  assign bus.hex = hex_q;
`else
  assign bus.hex = 8'hFF;
`endif

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: vector table drives two instances (1 and 3 ticks per step),
// expected lamp/phase/hex values are queued at drive time and checked when their cycle arrives.
module tb_tail_light_sequencer;
  typedef struct {
    logic       d;
    logic       rst;
    logic [3:0] sw;      // {hazards, turn_en, turn_right, brake}
    logic       tick;
    int         toff;
    int         n;
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] ph;
  } vec_t;

  typedef struct {
    int         stamp;
    int         id;
    logic       d;
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] ph;
    logic [7:0] hx;
  } exp_t;

  logic   clk;
  logic   reset_n;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_miss = 0;
  int     next_id = 0;
  vec_t   vecs[$];
  exp_t   sb[$];
  exp_t   e;

  tail_light_sequencer_if if0 ();
  tail_light_sequencer_if if1 ();

  tail_light_sequencer #(.TICKS_PER_STEP(1)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  tail_light_sequencer #(.TICKS_PER_STEP(3)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] hex_of(input logic [1:0] ph);
`ifdef TAIL_LIGHT_HEX_EN
    logic [7:0] s;
    case (ph)
      2'd0:    s = 8'hC0;
      2'd1:    s = 8'hF9;
      2'd2:    s = 8'hA4;
      default: s = 8'hB0;
    endcase
    return s;
`else
    return (ph == ph) ? 8'hFF : 8'h00;
`endif
  endfunction

  function automatic vec_t mk(input logic d, input logic rst, input logic [3:0] sw,
                              input logic tick, input int toff, input int n,
                              input logic [2:0] l, input logic [2:0] r, input logic [1:0] ph);
    vec_t v;
    v.d = d; v.rst = rst; v.sw = sw; v.tick = tick; v.toff = toff; v.n = n;
    v.l = l; v.r = r; v.ph = ph;
    return v;
  endfunction

  task automatic push_exp(input logic d, input int stamp, input logic [2:0] l,
                          input logic [2:0] r, input logic [1:0] ph);
    exp_t x;
    x.stamp = stamp; x.id = next_id; x.d = d;
    x.l = l; x.r = r; x.ph = ph; x.hx = hex_of(ph);
    next_id++;
    sb.push_back(x);
  endtask

  task automatic set_in(input logic d, input logic [3:0] sw, input logic tick);
    if (d == 1'b0) begin
      {if0.hazards, if0.turn_en, if0.turn_right, if0.brake} = sw;
      if0.tick = tick;
    end else begin
      {if1.hazards, if1.turn_en, if1.turn_right, if1.brake} = sw;
      if1.tick = tick;
    end
  endtask

  task automatic apply(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      reset_n = !(v.rst && (k == 0));
      set_in(v.d, v.sw, v.tick && (k == v.toff));
      if (k == 0) push_exp(v.d, cyc + v.n, v.l, v.r, v.ph);
      @(posedge clk);
      #1;
    end
    reset_n  = 1'b1;
    if0.tick = 1'b0;
    if1.tick = 1'b0;
  endtask

  task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s vec%0d @cyc%0d: got %h want %h", nm, id, cyc, got, want);
    end
  endtask

  // Scoreboard: compare each queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.stamp != cyc) begin
        n_miss++;
        $display("FAIL late vec%0d: stamp %0d checked at %0d", e.id, e.stamp, cyc);
      end else begin
        chk("left_leds",  e.id, 8'(e.d ? if1.left_leds  : if0.left_leds),  8'(e.l));
        chk("right_leds", e.id, 8'(e.d ? if1.right_leds : if0.right_leds), 8'(e.r));
        chk("phase",      e.id, 8'(e.d ? if1.phase      : if0.phase),      8'(e.ph));
        chk("hex",        e.id, e.d ? if1.hex : if0.hex, e.hx);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 4'b1111, 1'b1);
    set_in(1'b1, 4'b1111, 1'b1);
    // Reset held with busy inputs: everything must read as cleared.
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, cyc + 1, 3'b000, 3'b000, 2'd0);
      push_exp(1'b1, cyc + 1, 3'b000, 3'b000, 2'd0);
      @(posedge clk);
      #1;
    end
    set_in(1'b0, 4'b0000, 1'b0);
    set_in(1'b1, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single-step instance: left turn sequence
    vecs.push_back(mk(0, 0, 4'b0100, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b001, 3'b000, 2'd1));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b011, 3'b000, 2'd2));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b111, 3'b000, 2'd3));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b001, 3'b000, 2'd1));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b011, 3'b000, 2'd2));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b111, 3'b000, 2'd3));
    // One-cycle reset at phase 3, then restart
    vecs.push_back(mk(0, 1, 4'b0100, 0, 0, 1, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0100, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b001, 3'b000, 2'd1));
    // Right turn, brake added at phase 2 without restart
    vecs.push_back(mk(0, 0, 4'b0110, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b001, 2'd1));
    vecs.push_back(mk(0, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b011, 2'd2));
    vecs.push_back(mk(0, 0, 4'b0111, 0, 0, 4, 3'b111, 3'b011, 2'd2));
    vecs.push_back(mk(0, 0, 4'b0111, 1, 0, 4, 3'b111, 3'b111, 2'd3));
    vecs.push_back(mk(0, 0, 4'b0111, 1, 0, 4, 3'b111, 3'b000, 2'd0));
    // Hazards with brake, tick held off, then hazard lockstep
    vecs.push_back(mk(0, 0, 4'b1001, 0, 0, 4, 3'b111, 3'b111, 2'd0));
    vecs.push_back(mk(0, 0, 4'b1001, 1, 0, 4, 3'b111, 3'b111, 2'd0));
    vecs.push_back(mk(0, 0, 4'b1000, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b1000, 1, 0, 4, 3'b001, 3'b001, 2'd1));
    vecs.push_back(mk(0, 0, 4'b1000, 1, 0, 4, 3'b011, 3'b011, 2'd2));
    vecs.push_back(mk(0, 0, 4'b1000, 1, 0, 4, 3'b111, 3'b111, 2'd3));
    vecs.push_back(mk(0, 0, 4'b1000, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    // Brake alone, idle, left turn with brake, brake released mid-step
    vecs.push_back(mk(0, 0, 4'b0001, 0, 0, 4, 3'b111, 3'b111, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 4, 3'b000, 3'b111, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0101, 1, 0, 4, 3'b001, 3'b111, 2'd1));
    vecs.push_back(mk(0, 0, 4'b0100, 1, 0, 4, 3'b011, 3'b000, 2'd2));
    // Direction flip with a tick landing on the mode-change edge
    vecs.push_back(mk(0, 0, 4'b0110, 1, 2, 3, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(0, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b001, 2'd1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    // Three-tick instance: hazard steps every third tick
    vecs.push_back(mk(1, 0, 4'b1000, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b001, 3'b001, 2'd1));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b001, 3'b001, 2'd1));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b001, 3'b001, 2'd1));
    vecs.push_back(mk(1, 0, 4'b1000, 1, 0, 4, 3'b011, 3'b011, 2'd2));
    // Left turn, leave prescaler part-way, then flip direction on a tick
    vecs.push_back(mk(1, 0, 4'b0100, 0, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0100, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0100, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0100, 1, 0, 4, 3'b001, 3'b000, 2'd1));
    vecs.push_back(mk(1, 0, 4'b0100, 1, 0, 4, 3'b001, 3'b000, 2'd1));
    vecs.push_back(mk(1, 0, 4'b0110, 1, 2, 3, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b000, 2'd0));
    vecs.push_back(mk(1, 0, 4'b0110, 1, 0, 4, 3'b000, 3'b001, 2'd1));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 4, 3'b000, 3'b000, 2'd0));

    foreach (vecs[i]) apply(vecs[i]);

    repeat (4) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      n_miss += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
